// File: rtl/multicycle_datapath.sv
// Multicycle RV32-style datapath: one instruction at a time through FETCH/DECODE/EXEC/MEM/WB.
// Control signals come from an external controller; the FSM here only sequences the datapath.
module multicycle_datapath #(
    parameter int          PC_W       = 8,
    parameter int          DATA_W     = 32,
    parameter int          DM_ADDRESS = 9,
    parameter int          ALU_CC_W   = 4,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic                  mem2reg,
    input  logic                  alu_src,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic                  branch,
    input  logic                  jump,
    input  logic [ALU_CC_W-1:0]   alu_cc,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DM_ADDRESS-1:0] dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic [6:0]            opcode,
    output logic [2:0]            funct3,
    output logic [6:0]            funct7,
    output logic [DATA_W-1:0]     alu_result,
    output logic [2:0]            state,
    output logic                  instr_done
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [ALU_CC_W-1:0] ALU_AND  = ALU_CC_W'(0);
    localparam logic [ALU_CC_W-1:0] ALU_OR   = ALU_CC_W'(1);
    localparam logic [ALU_CC_W-1:0] ALU_ADD  = ALU_CC_W'(2);
    localparam logic [ALU_CC_W-1:0] ALU_XOR  = ALU_CC_W'(3);
    localparam logic [ALU_CC_W-1:0] ALU_SLL  = ALU_CC_W'(4);
    localparam logic [ALU_CC_W-1:0] ALU_SRL  = ALU_CC_W'(5);
    localparam logic [ALU_CC_W-1:0] ALU_SUB  = ALU_CC_W'(6);
    localparam logic [ALU_CC_W-1:0] ALU_SLT  = ALU_CC_W'(7);
    localparam logic [ALU_CC_W-1:0] ALU_SRA  = ALU_CC_W'(8);
    localparam logic [ALU_CC_W-1:0] ALU_SLTU = ALU_CC_W'(9);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] link_q, link_d;
    logic [DATA_W-1:0] rf_q [32];

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              done;

    logic [4:0]        rs1, rs2;
    logic [DATA_W-1:0] rs1_val, rs2_val;
    logic [31:0]       imm32;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] alu_b, alu_y;
    logic [4:0]        shamt;
    logic [PC_W-1:0]   pc_plus4, pc_target;

    assign rs1     = ir_q[19:15];
    assign rs2     = ir_q[24:20];
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    always_comb begin
        imm32 = '0;
        case (ir_q[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            7'b0100011:
                imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            7'b1100011:
                imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            7'b1101111:
                imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm_ext = DATA_W'($signed(imm32));

    assign alu_b = alu_src ? imm_q : b_q;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_y = '0;
        case (alu_cc)
            ALU_AND:  alu_y = a_q & alu_b;
            ALU_OR:   alu_y = a_q | alu_b;
            ALU_ADD:  alu_y = a_q + alu_b;
            ALU_XOR:  alu_y = a_q ^ alu_b;
            ALU_SLL:  alu_y = a_q << shamt;
            ALU_SRL:  alu_y = a_q >> shamt;
            ALU_SUB:  alu_y = a_q - alu_b;
            ALU_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
            ALU_SRA:  alu_y = $signed(a_q) >>> shamt;
            ALU_SLTU: alu_y = {{(DATA_W-1){1'b0}}, (a_q < alu_b)};
            default:  alu_y = '0;
        endcase
    end

    // PC arithmetic is PC_W wide so it wraps naturally.
    assign pc_plus4  = pc_q + PC_W'(4);
    assign pc_target = pc_q + imm_q[PC_W-1:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        link_d    = link_q;
        rf_we     = 1'b0;
        rf_waddr  = ir_q[11:7];
        rf_wdata  = jump ? link_q : (mem2reg ? mdr_q : alu_out_q);
        done      = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rs1_val;
                b_d     = rs2_val;
                imm_d   = imm_ext;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_out_d = alu_y;
                if (branch && (alu_y == '0)) begin
                    pc_d = pc_target;
                end else if (jump) begin
                    pc_d   = pc_target;
                    link_d = DATA_W'(pc_plus4);
                end else begin
                    pc_d = pc_plus4;
                end
                if (mem_read || mem_write) begin
                    state_d = S_MEM;
                end else if (reg_write || jump) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                    done    = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    // A simultaneous read and write is a store, so MDR is left alone.
                    if (!mem_write) begin
                        mdr_d = dmem_rdata;
                    end
                    if (reg_write) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        done    = 1'b1;
                    end
                end
            end
            S_WB: begin
                rf_we   = (rf_waddr != 5'd0);
                done    = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= PC_W'(RESET_PC);
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            link_q    <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            link_q    <= link_d;
            if (rf_we) begin
                rf_q[rf_waddr] <= rf_wdata;
            end
        end
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = (state_q == S_MEM) && mem_write;
    assign dmem_addr  = alu_out_q[DM_ADDRESS-1:0];
    assign dmem_wdata = b_q;
    assign opcode     = ir_q[6:0];
    assign funct3     = ir_q[14:12];
    assign funct7     = ir_q[31:25];
    assign alu_result = alu_out_q;
    assign state      = state_q;
    assign instr_done = done;

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- PC_W, 8, program counter width
- DATA_W, 32, datapath width
- DM_ADDRESS, 9, data memory address width
- ALU_CC_W, 4, ALU control code width
- RESET_PC, 0, PC value loaded at reset
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock; all state updates on its rising edge
- reset, in, 1, asynchronous active-low reset
- reg_write / mem2reg / alu_src / mem_write / mem_read / branch / jump, in, 1 each, control from the external controller
- alu_cc, in, ALU_CC_W, ALU operation code
- imem_req, out, 1, instruction fetch request
- imem_addr, out, PC_W, fetch address
- imem_ready, in, 1, fetch completes this cycle
- imem_rdata, in, 32, fetched instruction
- dmem_req, out, 1, data access request
- dmem_we, out, 1, 1 = store, 0 = load
- dmem_addr, out, DM_ADDRESS, ALUOut[DM_ADDRESS-1:0]
- dmem_wdata, out, DATA_W, rs2 register B
- dmem_ready, in, 1, data access completes this cycle
- dmem_rdata, in, DATA_W, load data
- opcode, out, 7, IR[6:0]
- funct3, out, 3, IR[14:12]
- funct7, out, 7, IR[31:25]
- alu_result, out, DATA_W, registered ALUOut
- state, out, 3, current FSM state encoding
- instr_done, out, 1, one-cycle pulse on instruction retirement

Function
REQ-003 FSM states and encodings SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; the block SHALL execute exactly one instruction at a time.
REQ-004 FETCH: imem_req=1 and imem_addr=PC while in FETCH; on the cycle imem_ready=1, IR <= imem_rdata and the next state is DECODE; otherwise the block stays in FETCH.
REQ-005 DECODE (1 cycle):
- A <= RF[IR[19:15]], B <= RF[IR[24:20]], IMM <= sign-extended immediate.
- Immediate type by opcode: I for 0010011/0000011/1100111; S for 0100011; B for 1100011; J for 1101111; 0 otherwise.
- Next state is EXEC.
REQ-006 The controller inputs SHALL be sampled from EXEC through WB; they are required stable while IR is held.
REQ-007 EXEC (1 cycle):
- ALUOut <= ALU(A, alu_src ? IMM : B).
- If branch=1 and the ALU result is zero: PC <= PC + IMM[PC_W-1:0].
- Else if jump=1: PC <= PC + IMM[PC_W-1:0] and LINK <= PC + 4.
- Else: PC <= PC + 4.
- All PC arithmetic SHALL wrap modulo 2^PC_W.
REQ-008 EXEC next state: MEM if mem_read or mem_write; else WB if reg_write or jump; else FETCH with instr_done=1.
REQ-009 ALU codes SHALL be 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SRA, 1001 SLTU; other codes give 0.
REQ-010 Shift amounts SHALL use operand bits [4:0]; add and subtract SHALL wrap at DATA_W.
REQ-011 MEM:
- dmem_req=1 and dmem_we=mem_write, held until dmem_ready=1.
- On dmem_ready=1 a load captures MDR <= dmem_rdata.
- Next state: WB if reg_write, else FETCH with instr_done=1.
REQ-012 If mem_read and mem_write are both 1, the access SHALL be treated as a store.
REQ-013 WB (1 cycle):
- RF[IR[11:7]] <= jump ? LINK : (mem2reg ? MDR : ALUOut).
- instr_done=1; next state is FETCH.
REQ-014 Writes to x0 SHALL be discarded; reads of x0 SHALL return 0.
REQ-015 Registers SHALL be written only in WB, and memory SHALL be written only by a MEM handshake.
REQ-016 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-017 Latency without stalls SHALL be: 3 cycles for branch/store-free no-write instructions, 4 for ALU-writeback or jump, 4 for store, 5 for load; each wait cycle adds 1.

Reset
REQ-018 reset=0 SHALL act asynchronously and clear all state:
- PC=RESET_PC, state=FETCH
- IR, A, B, IMM, ALUOut, MDR, LINK = 0
- all 32 registers = 0
- outputs: imem_req=1 after reset, dmem_req=0, instr_done=0, alu_result=0
REQ-019 Reset asserted mid-instruction SHALL abort it, with no register-file write and no further dmem_req; fetch SHALL resume at RESET_PC on the first rising clk edge after reset deasserts.

Verification
REQ-020 The bench SHALL cover the following scenarios:
- Reset then fetch addi x1,x0,5 with imem_ready=1 and alu_src=1, reg_write=1, alu_cc=0010 -> x1=5, PC=4, instr_done on the 4th cycle.
- sw x1,8(x0) with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_addr=8, dmem_wdata=5, no RF write.
- lw x2,8(x0) returning 5 -> x2=5 after 5 cycles; addi x0,x0,7 -> x0 stays 0.
- beq x1,x1,-4 at PC=8 -> PC=4; taken branch with PC=0 and offset -4 -> PC=252 (wrap, PC_W=8).
- jal x3,+16 at PC=12 -> x3=16, PC=28.
- reset pulse during a MEM wait -> no dmem_req after reset, registers=0, imem_addr=RESET_PC.
